// File: rtl/mem_addr_seq_if.sv
// ---------------------------------------------------------------------------
// mem_addr_seq_if
// Purpose : bundles the request, source, exception and memory-handshake
//           signals of mem_addr_seq into one interface.
// Modports:
//   master - drives req/sel/src_flat/word_acc/exc_req/exc_code/mem_ack,
//            observes mem_addr/addr_valid/busy/done/sel_err/timeout/align_err
//   slave  - the sequencer side (directions reversed)
// ---------------------------------------------------------------------------
interface mem_addr_seq_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_SRC   = 5,
  parameter int SEL_W     = 3,
  parameter int VEC_IDX_W = 2
);
  logic                      req;
  logic [SEL_W-1:0]          sel;
  logic [NUM_SRC*DATA_W-1:0] src_flat;
  logic                      word_acc;
  logic                      exc_req;
  logic [VEC_IDX_W-1:0]      exc_code;
  logic                      mem_ack;
  logic [DATA_W-1:0]         mem_addr;
  logic                      addr_valid;
  logic                      busy;
  logic                      done;
  logic                      sel_err;
  logic                      timeout;
  logic                      align_err;

  modport master (
    output req, sel, src_flat, word_acc, exc_req, exc_code, mem_ack,
    input  mem_addr, addr_valid, busy, done, sel_err, timeout, align_err
  );

  modport slave (
    input  req, sel, src_flat, word_acc, exc_req, exc_code, mem_ack,
    output mem_addr, addr_valid, busy, done, sel_err, timeout, align_err
  );
endinterface

// File: rtl/mem_addr_seq.sv
// ---------------------------------------------------------------------------
// mem_addr_seq
// Purpose : registered memory-address source selector. Latches src[sel] (or
//           an exception-vector address) and holds it on mem_addr until the
//           memory acknowledges, with exception override, a hold timeout and
//           select-range error reporting.
// Ports   :
//   i_clk   - system clock, rising edge
//   i_reset - synchronous, active-high reset (priority over everything)
//   bus     - mem_addr_seq_if.slave (request/source/exception inputs,
//             mem_ack in; mem_addr, addr_valid, busy, done, sel_err,
//             timeout, align_err out; all outputs registered)
// Options :
//   MEM_ADDR_ALIGN_CHECK_EN - when defined, align_err flags a word access to
//   an address whose two low bits are non-zero; otherwise align_err is 0.
// ---------------------------------------------------------------------------
module mem_addr_seq #(
  parameter int DATA_W      = 32,
  parameter int NUM_SRC     = 5,
  parameter int SEL_W       = 3,
  parameter int VEC_BASE    = 253,
  parameter int NUM_VEC     = 3,
  parameter int VEC_IDX_W   = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  mem_addr_seq_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_EXC  = 2'd2
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_mem_addr;
  logic               r_addr_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_sel_err;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_next_state;
  logic               w_load;
  logic [DATA_W-1:0]  w_load_addr;
  logic               w_valid_next;
  logic               w_done;
  logic               w_sel_err;
  logic               w_timeout;
  logic               w_sel_ok;
  logic               w_tmo_hit;
  logic [DATA_W-1:0]  w_vec_idx;
  logic [DATA_W-1:0]  w_vec_addr;
  logic [DATA_W-1:0]  w_src_sel;

  // Source table padded to the full sel range; out-of-range entries read 0,
  // which is exactly the address an invalid select must present.
  logic [DATA_W-1:0]  w_src_arr [2**SEL_W];

  genvar gi;
  generate
    for (gi = 0; gi < 2**SEL_W; gi++) begin : g_src
      if (gi < NUM_SRC) begin : g_used
        assign w_src_arr[gi] = bus.src_flat[gi*DATA_W +: DATA_W];
      end else begin : g_pad
        assign w_src_arr[gi] = '0;
      end
    end
  endgenerate

  assign w_src_sel = w_src_arr[bus.sel];
  assign w_sel_ok  = (32'(bus.sel) < NUM_SRC);

  // Exception code clamps to the last vector; base + index never wraps.
  assign w_vec_idx  = (32'(bus.exc_code) > NUM_VEC - 1) ? DATA_W'(NUM_VEC - 1)
                                                       : DATA_W'(bus.exc_code);
  assign w_vec_addr = DATA_W'(VEC_BASE) + w_vec_idx;

  assign w_tmo_hit  = (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);

  // Next-state and registered-output decode.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_addr  = r_mem_addr;
    w_valid_next = r_addr_valid;
    w_done       = 1'b0;
    w_sel_err    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.exc_req) begin
          // Exception wins; a simultaneous req is dropped, not queued.
          w_load       = 1'b1;
          w_load_addr  = w_vec_addr;
          w_valid_next = 1'b1;
          w_next_state = ST_EXC;
        end else if (bus.req) begin
          w_load       = 1'b1;
          w_load_addr  = w_src_sel;
          w_sel_err    = ~w_sel_ok;
          w_valid_next = 1'b1;
          w_next_state = ST_HOLD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (bus.exc_req) begin
          // Override keeps addr_valid high; an ack in the same cycle still
          // completes the normal access.
          w_load       = 1'b1;
          w_load_addr  = w_vec_addr;
          w_done       = bus.mem_ack;
          w_valid_next = 1'b1;
          w_next_state = ST_EXC;
        end else if (bus.mem_ack) begin
          w_done       = 1'b1;
          w_valid_next = 1'b0;
          w_next_state = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_valid_next = 1'b0;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      ST_EXC: begin
        if (bus.mem_ack) begin
          w_done       = 1'b1;
          w_valid_next = 1'b0;
          w_next_state = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_timeout    = 1'b1;
          w_valid_next = 1'b0;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_EXC;
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, address and pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_mem_addr   <= '0;
      r_addr_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sel_err    <= 1'b0;
      r_timeout    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_next_state;
      if (w_load) begin
        r_mem_addr <= w_load_addr;
      end
      r_addr_valid <= w_valid_next;
      r_busy       <= (w_next_state != ST_IDLE);
      r_done       <= w_done;
      r_sel_err    <= w_sel_err;
      r_timeout    <= w_timeout;
      // Any (re)load or return to IDLE restarts the hold count; staying put
      // implies no ack this cycle.
      if (w_load || (w_next_state == ST_IDLE) || (TIMEOUT_CYC == 0)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.mem_addr   = r_mem_addr;
  assign bus.addr_valid = r_addr_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.sel_err    = r_sel_err;
  assign bus.timeout    = r_timeout;

`ifdef MEM_ADDR_ALIGN_CHECK_EN
  logic r_align_err;

  // Alignment flag: evaluated on each load, held for the access.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_align_err <= 1'b0;
    end else if (w_load) begin
      r_align_err <= bus.word_acc & (w_load_addr[1:0] != 2'b00);
    end else if (w_next_state == ST_IDLE) begin
      r_align_err <= 1'b0;
    end
  end

  assign bus.align_err = r_align_err;
`else
  logic w_unused_word_acc;
  assign w_unused_word_acc = bus.word_acc;
  assign bus.align_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_addr_seq
// Directed stimulus for mem_addr_seq. Expected output events are queued as
// stimulus is issued; a negedge monitor pops and compares whenever the DUT
// shows an event (new valid address, done, sel_err or timeout pulse).
// ---------------------------------------------------------------------------
module tb_mem_addr_seq;
  localparam int DATA_W = 32;

`ifdef MEM_ADDR_ALIGN_CHECK_EN
  localparam logic ALIGN_ON = 1'b1;
`else
  localparam logic ALIGN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_addr_seq_if #(.DATA_W(32), .NUM_SRC(5), .SEL_W(3), .VEC_IDX_W(2)) bus ();

  mem_addr_seq #(
    .DATA_W(32), .NUM_SRC(5), .SEL_W(3), .VEC_BASE(253),
    .NUM_VEC(3), .VEC_IDX_W(2), .TIMEOUT_CYC(16)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] addr;
    logic              done;
    logic              sel_err;
    logic              tmo;
    logic              align;
    logic              busy;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic obs_t mk(logic v, logic [DATA_W-1:0] a, logic d,
                              logic se, logic t, logic al, logic b);
    obs_t o;
    o.valid = v; o.addr = a; o.done = d; o.sel_err = se;
    o.tmo = t; o.align = al; o.busy = b;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("v=%0b a=%h d=%0b se=%0b to=%0b al=%0b b=%0b",
                     o.valid, o.addr, o.done, o.sel_err, o.tmo, o.align, o.busy);
  endfunction

  task automatic push(obs_t o);
    exp_q.push_back(o);
  endtask

  task automatic check_obs(obs_t got);
    obs_t want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s, wanted no event", fmt(got));
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL event: got %s, wanted %s", fmt(got), fmt(want));
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(int i, logic [DATA_W-1:0] v);
    bus.src_flat[i*DATA_W +: DATA_W] = v;
  endtask

  // Monitor: compare every visible output event against the queue.
  logic              prev_valid;
  logic [DATA_W-1:0] prev_addr;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done || bus.sel_err || bus.timeout ||
          (bus.addr_valid && (!prev_valid || bus.mem_addr != prev_addr))) begin
        check_obs(mk(bus.addr_valid, bus.mem_addr, bus.done, bus.sel_err,
                     bus.timeout, bus.align_err, bus.busy));
      end
    end
    prev_valid <= bus.addr_valid;
    prev_addr  <= bus.mem_addr;
  end

  initial begin
    bus.req = 1'b0; bus.sel = 3'd0; bus.src_flat = '0; bus.word_acc = 1'b0;
    bus.exc_req = 1'b0; bus.exc_code = 2'd0; bus.mem_ack = 1'b0;
    set_src(0, 32'h0000_0040);
    set_src(1, 32'h0000_0042);
    set_src(2, 32'h0000_0200);
    set_src(3, 32'h0000_0300);
    set_src(4, 32'h0000_0100);

    // Reset for two cycles with req held high.
    reset = 1'b1; bus.req = 1'b1;
    cyc(); cyc();
    chk("rst_addr",  bus.mem_addr,   32'd0);
    chk("rst_valid", bus.addr_valid, 32'd0);
    chk("rst_busy",  bus.busy,       32'd0);
    chk("rst_done",  bus.done,       32'd0);
    chk("rst_selerr", bus.sel_err,   32'd0);
    chk("rst_tmo",   bus.timeout,    32'd0);
    chk("rst_align", bus.align_err,  32'd0);
    reset = 1'b0; bus.req = 1'b0;
    cyc();

    // Normal access, src0, held 3 cycles while req/sel are ignored.
    bus.sel = 3'd0; bus.req = 1'b1;
    push(mk(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc();
    chk("t1_latency_valid", bus.addr_valid, 32'd1);
    bus.sel = 3'd2;
    repeat (3) cyc();
    bus.req = 1'b0;
    chk("t1_hold_addr", bus.mem_addr, 32'h40);
    bus.mem_ack = 1'b1;
    push(mk(1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    bus.mem_ack = 1'b0;
    chk("t1_ack_valid", bus.addr_valid, 32'd0);
    cyc();
    chk("t1_done_pulse", bus.done, 32'd0);

    // Exception override from HOLD, no nesting in EXC, then clamp from IDLE.
    bus.word_acc = 1'b1; bus.sel = 3'd4; bus.req = 1'b1;
    push(mk(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc();
    bus.req = 1'b0;
    cyc();
    bus.exc_req = 1'b1; bus.exc_code = 2'd1;
    push(mk(1'b1, 32'd254, 1'b0, 1'b0, 1'b0, ALIGN_ON, 1'b1));
    cyc();
    bus.exc_req = 1'b0;
    chk("t2_vec1", bus.mem_addr, 32'd254);
    cyc();
    bus.exc_req = 1'b1; bus.exc_code = 2'd0;
    cyc();
    bus.exc_req = 1'b0;
    chk("t2_no_nest", bus.mem_addr, 32'd254);
    bus.mem_ack = 1'b1;
    push(mk(1'b0, 32'd254, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    bus.mem_ack = 1'b0;
    bus.exc_req = 1'b1; bus.exc_code = 2'd3; bus.req = 1'b1; bus.sel = 3'd0;
    push(mk(1'b1, 32'd255, 1'b0, 1'b0, 1'b0, ALIGN_ON, 1'b1));
    cyc();
    bus.exc_req = 1'b0; bus.req = 1'b0;
    chk("t2_clamp", bus.mem_addr, 32'd255);
    bus.mem_ack = 1'b1;
    push(mk(1'b0, 32'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    bus.mem_ack = 1'b0; bus.word_acc = 1'b0;

    // Exception and ack in the same HOLD cycle.
    bus.sel = 3'd2; bus.req = 1'b1;
    push(mk(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc();
    bus.req = 1'b0; bus.exc_req = 1'b1; bus.exc_code = 2'd0; bus.mem_ack = 1'b1;
    push(mk(1'b1, 32'd253, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc();
    bus.exc_req = 1'b0; bus.mem_ack = 1'b0;
    bus.mem_ack = 1'b1;
    push(mk(1'b0, 32'd253, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    bus.mem_ack = 1'b0;

    // Select out of range.
    bus.word_acc = 1'b1; bus.sel = 3'd7; bus.req = 1'b1;
    push(mk(1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc();
    bus.req = 1'b0; bus.sel = 3'd0;
    cyc();
    chk("t3_selerr_pulse", bus.sel_err, 32'd0);
    chk("t3_valid", bus.addr_valid, 32'd1);
    bus.mem_ack = 1'b1;
    push(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    bus.mem_ack = 1'b0; bus.word_acc = 1'b0;

    // Timeout after 16 hold cycles without ack.
    bus.sel = 3'd3; bus.req = 1'b1;
    push(mk(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc();
    bus.req = 1'b0;
    repeat (15) cyc();
    chk("t4_pre_valid", bus.addr_valid, 32'd1);
    chk("t4_pre_tmo", bus.timeout, 32'd0);
    push(mk(1'b0, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc();
    chk("t4_tmo", bus.timeout, 32'd1);
    chk("t4_tmo_busy", bus.busy, 32'd0);
    cyc();
    chk("t4_tmo_pulse", bus.timeout, 32'd0);

    // Ack on the timeout cycle wins.
    bus.req = 1'b1;
    push(mk(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc();
    bus.req = 1'b0;
    repeat (15) cyc();
    bus.mem_ack = 1'b1;
    push(mk(1'b0, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    bus.mem_ack = 1'b0;
    chk("t4_ack_wins", bus.timeout, 32'd0);

    // Misaligned word access.
    bus.word_acc = 1'b1; bus.sel = 3'd1; bus.req = 1'b1;
    push(mk(1'b1, 32'h42, 1'b0, 1'b0, 1'b0, ALIGN_ON, 1'b1));
    cyc();
    bus.req = 1'b0;
    cyc();
    chk("t5_align_held", bus.align_err, {31'd0, ALIGN_ON});
    bus.mem_ack = 1'b1;
    push(mk(1'b0, 32'h42, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc();
    bus.mem_ack = 1'b0; bus.word_acc = 1'b0;
    chk("t5_align_clear", bus.align_err, 32'd0);

    // Reset in the middle of a hold.
    bus.sel = 3'd0; bus.req = 1'b1;
    push(mk(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc();
    bus.req = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_rst_valid", bus.addr_valid, 32'd0);
    chk("t6_rst_addr", bus.mem_addr, 32'd0);
    chk("t6_rst_busy", bus.busy, 32'd0);

    cyc(); cyc();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_addr_seq.md
Name: mem_addr_seq

Overview:
- Parametrised, registered successor to the memory-address source selector in the multi-cycle datapath.
- Selects one of NUM_SRC address sources, or an exception-vector address, and holds it stable on the memory address port until the memory acknowledges.
- Adds a request/ack handshake, exception override, a hold timeout and select-range error reporting.
- Sits between the control unit / PC / ALU-out registers and the memory's address input.

Parameters:
- DATA_W, 32, address width in bits.
- NUM_SRC, 5, number of selectable address sources (index 0 = PC source).
- SEL_W, 3, width of sel; must satisfy 2^SEL_W >= NUM_SRC.
- VEC_BASE, 253, address of exception vector 0.
- NUM_VEC, 3, number of exception vectors (VEC_BASE .. VEC_BASE+NUM_VEC-1).
- VEC_IDX_W, 2, width of exc_code.
- TIMEOUT_CYC, 16, maximum cycles an address is held without mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request: latch src[sel] and present it.
- sel  in  SEL_W  source index.
- src_flat  in  NUM_SRC*DATA_W  sources packed; src i = bits [i*DATA_W +: DATA_W].
- word_acc  in  1  access is a word access (used by the alignment check).
- exc_req  in  1  exception request, single-cycle pulse.
- exc_code  in  VEC_IDX_W  exception vector index.
- mem_ack  in  1  memory has consumed the current address.
- mem_addr  out  DATA_W  registered address to memory.
- addr_valid  out  1  mem_addr is valid and held.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, access acknowledged.
- sel_err  out  1  one-cycle pulse, sel >= NUM_SRC on an accepted req.
- timeout  out  1  one-cycle pulse, hold aborted by timeout.
- align_err  out  1  alignment error (see Optional Feature).

Behaviour:
- Reset: state=IDLE; mem_addr=0; addr_valid, busy, done, sel_err, timeout, align_err=0; hold counter=0. Reset has priority over every other input, including mid-hold.
- FSM states: IDLE, HOLD (normal access), EXC (vector access).
- IDLE, exc_req=1: mem_addr <= VEC_BASE + min(exc_code, NUM_VEC-1); addr_valid<=1; go to EXC. A simultaneous req is ignored and is not queued.
- IDLE, req=1 and exc_req=0: mem_addr <= src[sel]; addr_valid<=1; go to HOLD.
  - If sel >= NUM_SRC: mem_addr <= 0 and sel_err pulses; the access still proceeds.
- Latency: request sampled at edge N; mem_addr and addr_valid are visible after edge N+1 (one cycle).
- HOLD/EXC: mem_addr is held stable; req, sel and src are ignored.
- HOLD/EXC, mem_ack=1: done pulses; addr_valid<=0; go to IDLE. A new req is accepted no earlier than the following cycle.
- HOLD, exc_req=1 (with or without mem_ack): vector loaded, go to EXC, addr_valid stays 1.
  - done pulses only if mem_ack=1 in the same cycle.
- EXC, exc_req: ignored (no nesting).
- Hold counter: cleared on entry to HOLD/EXC, increments each cycle without mem_ack.
  - When TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC-1 without mem_ack: timeout pulses, addr_valid<=0, go to IDLE.
  - mem_ack in that same cycle wins: done pulses, timeout does not.
- Vector arithmetic is unsigned DATA_W and does not wrap.
- mem_addr keeps its last value in IDLE.

Optional Feature:
- Macro: MEM_ADDR_ALIGN_CHECK_EN.
- Defined: on every address load, align_err <= word_acc & (loaded_addr[1:0] != 0). It is held for the whole access and cleared on return to IDLE. The access is not blocked.
  - Vector addresses are checked the same way, so VEC_BASE=253 with word_acc=1 flags.
- Undefined: align_err is constant 0; no check logic is synthesised.

Test Plan:
- Reset: assert reset 2 cycles with req=1 -> all outputs 0, state IDLE, mem_addr=0.
- Normal access: src0=0x0000_0040, sel=0, req pulse at N -> mem_addr=0x40 and addr_valid=1 from N+1; hold 3 cycles; mem_ack -> done pulse, addr_valid=0 next cycle.
- Exception override: in HOLD with sel=4 (src4=0x100), exc_req with exc_code=1 -> mem_addr=254 next cycle, state EXC; exc_code=3 -> mem_addr=255 (clamped).
- Select error: sel=7 with NUM_SRC=5 -> sel_err one-cycle pulse, mem_addr=0, addr_valid=1.
- Timeout: TIMEOUT_CYC=16, no mem_ack -> timeout pulse in the 16th hold cycle, addr_valid=0, IDLE. Repeat with mem_ack on that cycle -> done pulses, timeout stays 0.
- Alignment (macro defined): src1=0x0000_0042, word_acc=1 -> align_err=1 during the access. Macro undefined -> align_err=0.
